// File: rtl/count_disp_pkg.sv
// Shared definitions for the count display driver: FSM states, conversion
// constants, the 7-segment lookup table and the double-dabble adjust step.
package count_disp_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_e;

    localparam logic [6:0] MAX_COUNT  = 7'd99;
    localparam int         CONV_ITERS = 7;

    // Segment patterns {g,f,e,d,c,b,a}; index 0 is the least significant entry.
    localparam logic [9:0][6:0] SEG_LUT = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // One double-dabble correction: a nibble of 5 or more gets 3 added so the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment decoder with a blanking input.
// Nibbles above 9 show a dash.
module bcd_to_seg7
    import count_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Select blank, the digit pattern, or the dash for non-decimal nibbles
    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else if (digit_i <= 4'd9) begin
            seg_o = SEG_LUT[digit_i];
        end else begin
            seg_o = SEG_DASH;
        end
    end

endmodule

// File: rtl/count_display_driver.sv
// Count display driver: accepts a 0..99 binary count over valid/ready,
// converts it to BCD with a 7-step sequential double-dabble, registers the
// BCD value and both digit patterns, and multiplexes them onto a 2-digit bus.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module count_display_driver
    import count_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,      // synchronous, active-high
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] in_count,
    output logic [7:0] bcd,
    output logic       bcd_valid,
    output logic       ovf,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [1:0] scan_an,
    output logic [6:0] scan_seg
);

    localparam int         SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [2:0] CONV_LAST = 3'(CONV_ITERS - 1);

    // Segment and anode registers hold the pin polarity directly.
    localparam logic [6:0] SEG_POL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0] AN_POL  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif

    localparam logic [6:0] SEG1_RST = (LZB ? SEG_BLANK : SEG_LUT[0]) ^ SEG_POL;
    localparam logic [6:0] SEG2_RST = SEG_LUT[0] ^ SEG_POL;
    localparam logic [1:0] AN_RST   = 2'b01 ^ AN_POL;

    state_e      state_q, state_d;
    logic [14:0] sh_q, sh_d;          // {tens, units, remaining binary bits}
    logic [2:0]  iter_q, iter_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic        in_ready_q, in_ready_d;
    logic [7:0]  bcd_q, bcd_d;
    logic        bcd_valid_q, bcd_valid_d;
    logic        ovf_q, ovf_d;
    logic [6:0]  seg1_q, seg1_d;
    logic [6:0]  seg2_q, seg2_d;

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        scan_an_q, scan_an_d;
    logic [6:0]        scan_seg_q, scan_seg_d;

    logic [14:0] adj_s;
    logic [14:0] shifted_s;
    logic [7:0]  out_bcd_s;
    logic        blank_tens_s;
    logic [6:0]  dec_tens_s;
    logic [6:0]  dec_units_s;
    logic [1:0]  an_logic_s;

    // One double-dabble iteration on the current shift register
    always_comb begin
        adj_s     = {dd_adjust(sh_q[14:11]), dd_adjust(sh_q[10:7]), sh_q[6:0]};
        shifted_s = {adj_s[13:0], 1'b0};
    end

    // Value to be published: saturated 99 on overflow, else the finished conversion
    always_comb begin
        out_bcd_s = shifted_s[14:7];
        if (ovf_pend_q) begin
            out_bcd_s = 8'h99;
        end else begin
            out_bcd_s = shifted_s[14:7];
        end
        blank_tens_s = LZB & (out_bcd_s[7:4] == 4'd0);
    end

    bcd_to_seg7 u_dec_tens (
        .digit_i (out_bcd_s[7:4]),
        .blank_i (blank_tens_s),
        .seg_o   (dec_tens_s)
    );

    bcd_to_seg7 u_dec_units (
        .digit_i (out_bcd_s[3:0]),
        .blank_i (1'b0),
        .seg_o   (dec_units_s)
    );

    // Handshake, conversion sequencing and result publication
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        iter_d      = iter_q;
        ovf_pend_d  = 1'b0;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        ovf_d       = ovf_q;
        seg1_d      = seg1_q;
        seg2_d      = seg2_q;

        // An out-of-range count accepted last edge is published now.
        if (ovf_pend_q) begin
            bcd_d       = out_bcd_s;
            seg1_d      = dec_tens_s ^ SEG_POL;
            seg2_d      = dec_units_s ^ SEG_POL;
            ovf_d       = 1'b1;
            bcd_valid_d = 1'b1;
        end else begin
            bcd_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_count <= MAX_COUNT) begin
                        sh_d    = {8'd0, in_count};
                        iter_d  = 3'd0;
                        state_d = CONVERT;
                    end else begin
                        ovf_pend_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                sh_d = shifted_s;
                if (iter_q == CONV_LAST) begin
                    state_d     = IDLE;
                    bcd_d       = out_bcd_s;
                    seg1_d      = dec_tens_s ^ SEG_POL;
                    seg2_d      = dec_units_s ^ SEG_POL;
                    ovf_d       = 1'b0;
                    bcd_valid_d = 1'b1;
                end else begin
                    iter_d = iter_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // Free-running digit scan; scan_seg follows the digit enabled after this edge
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_an_d  = scan_an_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = SCAN_W'(0);
            scan_an_d  = {scan_an_q[0], scan_an_q[1]};
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
        an_logic_s = scan_an_d ^ AN_POL;
        if (an_logic_s[0]) begin
            scan_seg_d = seg2_q;
        end else begin
            scan_seg_d = seg1_q;
        end
    end

    // Conversion FSM, datapath and published result registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            sh_q        <= 15'd0;
            iter_q      <= 3'd0;
            ovf_pend_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            bcd_q       <= 8'h00;
            bcd_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            seg1_q      <= SEG1_RST;
            seg2_q      <= SEG2_RST;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            iter_q      <= iter_d;
            ovf_pend_q  <= ovf_pend_d;
            in_ready_q  <= in_ready_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            ovf_q       <= ovf_d;
            seg1_q      <= seg1_d;
            seg2_q      <= seg2_d;
        end
    end

    // Display multiplex registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            scan_cnt_q <= SCAN_W'(0);
            scan_an_q  <= AN_RST;
            scan_seg_q <= SEG2_RST;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_an_q  <= scan_an_d;
            scan_seg_q <= scan_seg_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign ovf       = ovf_q;
    assign seg1      = seg1_q;
    assign seg2      = seg2_q;
    assign scan_an   = scan_an_q;
    assign scan_seg  = scan_seg_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Randomised self-checking bench for count_display_driver. A transaction-level
// model (decimal arithmetic, a result queue with due cycles and a slot counter)
// predicts every output each cycle for an active-high and an active-low instance.
module tb_count_display_driver;

    localparam int SCAN_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [6:0] in_count;

    logic       in_ready, bcd_valid, ovf;
    logic [7:0] bcd;
    logic [6:0] seg1, seg2, scan_seg;
    logic [1:0] scan_an;

    logic       in_ready_n, bcd_valid_n, ovf_n;
    logic [7:0] bcd_n;
    logic [6:0] seg1_n, seg2_n, scan_seg_n;
    logic [1:0] scan_an_n;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        int         due;
        logic [7:0] bcd;
        logic       ovf;
    } res_t;

    res_t q[$];
    int   cyc      = 0;
    int   ready_at = 0;
    int   since    = 0;
    bit   started  = 1'b0;
    logic [7:0] m_bcd;
    logic       m_ovf;
    logic [6:0] m_seg1, m_seg2, m_sseg;
    logic [1:0] m_an;

    count_display_driver #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_count(in_count), .bcd(bcd), .bcd_valid(bcd_valid), .ovf(ovf),
        .seg1(seg1), .seg2(seg2), .scan_an(scan_an), .scan_seg(scan_seg)
    );

    count_display_driver #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) u_dut_inv (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_count(in_count), .bcd(bcd_n), .bcd_valid(bcd_valid_n), .ovf(ovf_n),
        .seg1(seg1_n), .seg2(seg2_n), .scan_an(scan_an_n), .scan_seg(scan_seg_n)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [6:0] tens_pattern(input logic [3:0] t);
        if (LZB && t == 4'd0) return 7'h00;
        return seg_tab[t];
    endfunction

    // Model: handshakes, scheduled results and the scan slot, advanced per edge
    always @(posedge clk) begin : model_edge
        res_t r;
        int   n;
        cyc++;
        started = 1'b1;
        if (rst_n) begin
            q.delete();
            ready_at = cyc;
            m_bcd    = 8'h00;
            m_ovf    = 1'b0;
            m_seg1   = tens_pattern(4'd0);
            m_seg2   = seg_tab[0];
            since    = 0;
            m_an     = 2'b01;
            m_sseg   = seg_tab[0];
        end else begin
            since++;
            m_an   = (((since / SCAN_DIV) % 2) == 1) ? 2'b10 : 2'b01;
            m_sseg = m_an[0] ? m_seg2 : m_seg1;
            if (in_valid && (cyc - 1 >= ready_at)) begin
                n = int'(in_count);
                if (n <= 99) begin
                    r.due    = cyc + 7;
                    r.bcd    = {4'(n / 10), 4'(n % 10)};
                    r.ovf    = 1'b0;
                    ready_at = cyc + 7;
                end else begin
                    r.due = cyc + 1;
                    r.bcd = 8'h99;
                    r.ovf = 1'b1;
                end
                q.push_back(r);
            end
        end
    end

    // Compare every output of both instances against the model each cycle
    always @(negedge clk) begin : model_check
        logic exp_v;
        if (started) begin
            exp_v = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_v  = 1'b1;
                m_bcd  = q[0].bcd;
                m_ovf  = q[0].ovf;
                m_seg1 = tens_pattern(m_bcd[7:4]);
                m_seg2 = seg_tab[m_bcd[3:0]];
                void'(q.pop_front());
            end
            check_eq("bcd_valid", 32'(bcd_valid), 32'(exp_v));
            check_eq("bcd", 32'(bcd), 32'(m_bcd));
            check_eq("ovf", 32'(ovf), 32'(m_ovf));
            check_eq("seg1", 32'(seg1), 32'(m_seg1));
            check_eq("seg2", 32'(seg2), 32'(m_seg2));
            check_eq("in_ready", 32'(in_ready), 32'(cyc >= ready_at));
            check_eq("scan_an", 32'(scan_an), 32'(m_an));
            check_eq("scan_seg", 32'(scan_seg), 32'(m_sseg));
            check_eq("inv_bcd_valid", 32'(bcd_valid_n), 32'(exp_v));
            check_eq("inv_bcd", 32'(bcd_n), 32'(m_bcd));
            check_eq("inv_seg1", 32'(seg1_n), 32'(m_seg1 ^ 7'h7F));
            check_eq("inv_seg2", 32'(seg2_n), 32'(m_seg2 ^ 7'h7F));
            check_eq("inv_scan_an", 32'(scan_an_n), 32'(m_an ^ 2'b11));
            check_eq("inv_scan_seg", 32'(scan_seg_n), 32'(m_sseg ^ 7'h7F));
        end
    end

    // Offer a count until it is accepted; optionally keep in_valid high afterwards
    task automatic send(input logic [6:0] n, input bit keep);
        bit acc;
        acc      = 1'b0;
        in_count = n;
        in_valid = 1'b1;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        check_eq("send_accept", 32'(acc), 32'd1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit keep;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_count = 7'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        idle(2);

        send(7'd0, 1'b0);   idle(9);
        send(7'd57, 1'b0);  idle(9);
        send(7'd120, 1'b0); idle(2);
        send(7'd42, 1'b0);  idle(9);
        send(7'd99, 1'b1);  send(7'd10, 1'b0); idle(9);
        send(7'd31, 1'b0);  idle(20);

        // Reset in the middle of a conversion
        send(7'd88, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        idle(3);

        for (int i = 0; i < 40; i++) begin
            keep = 1'($urandom_range(0, 1));
            send(7'($urandom_range(0, 127)), keep);
            if (!keep) idle($urandom_range(0, 3));
        end
        idle(12);
        check_eq("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
